// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: composites sprite layer over background with a 2-cycle pipeline and collision status
module sprite_layer_mixer #(
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter logic [7:0]  CTRL_RESET = 8'h05
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [7:0] bg_r,
  input  logic [7:0] bg_g,
  input  logic [7:0] bg_b,
  input  logic       bg_opaque,
  input  logic [7:0] spr_r,
  input  logic [7:0] spr_g,
  input  logic [7:0] spr_b,
  input  logic       spr_a,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_hblank,
  output logic       out_vblank
);
  logic [2:0]  ctrl;
  logic        s1_hs, s1_vs, s1_hb, s1_vb;
  logic        s1_spr, s1_bg, s1_blank, s1_pri, s1_bgen;
  logic [23:0] s1_spr_rgb, s1_bg_rgb, mix;
  logic        coll, seen;
  // control register; only the three defined bits have any effect, so only they are kept
  always_ff @(posedge clk or negedge reset)
    if (!reset) ctrl <= CTRL_RESET[2:0];
    else if (cpu_wr) ctrl <= cpu_din[2:0];
  // stage 1: capture pixel, timing and the layer enables gated by the current ctrl
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {s1_hs, s1_vs, s1_hb, s1_vb} <= '0;
      {s1_spr, s1_bg, s1_blank, s1_pri, s1_bgen} <= '0;
      s1_spr_rgb <= '0;
      s1_bg_rgb <= '0;
    end else begin
      {s1_hs, s1_vs, s1_hb, s1_vb} <= {hsync, vsync, hblank, vblank};
      s1_spr <= spr_a & ctrl[0];
      s1_bg <= bg_opaque & ctrl[2];
      s1_blank <= hblank | vblank;
      s1_pri <= ctrl[1];
      s1_bgen <= ctrl[2];
      s1_spr_rgb <= {spr_r, spr_g, spr_b};
      s1_bg_rgb <= {bg_r, bg_g, bg_b};
    end
  // stage 2 colour select: border, then sprite unless a solid bg has priority, then bg, else black
  always_comb
    mix = s1_blank ? BORDER_RGB :
          (s1_spr & ~(s1_pri & s1_bg)) ? s1_spr_rgb :
          s1_bgen ? s1_bg_rgb : 24'h000000;
  // stage 2 output registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {out_r, out_g, out_b} <= '0;
      {out_hsync, out_vsync, out_hblank, out_vblank} <= '0;
    end else begin
      {out_r, out_g, out_b} <= mix;
      {out_hsync, out_vsync, out_hblank, out_vblank} <= {s1_hs, s1_vs, s1_hb, s1_vb};
    end
  // sticky status: a read clears, but a coincident new event keeps the bit set
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      coll <= 1'b0;
      seen <= 1'b0;
    end else begin
      coll <= (coll & ~cpu_rd) | (s1_spr & s1_bg & ~s1_blank);
      seen <= (seen & ~cpu_rd) | (s1_spr & ~s1_blank);
    end
  assign cpu_dout = {5'b0, s1_vb, seen, coll};
endmodule

// File: tb/tb_sprite_layer_mixer.sv
// tb_sprite_layer_mixer: scoreboard bench for sprite_layer_mixer
module tb_sprite_layer_mixer;
  localparam logic [23:0] BORDER = 24'h000000;
  logic       clk = 0, reset = 0;
  logic       hsync, vsync, hblank, vblank, bg_opaque, spr_a, cpu_wr, cpu_rd;
  logic [7:0] bg_r, bg_g, bg_b, spr_r, spr_g, spr_b, cpu_din, cpu_dout;
  logic [7:0] out_r, out_g, out_b;
  logic       out_hsync, out_vsync, out_hblank, out_vblank;
  int         n_cmp = 0, n_bad = 0;
  logic [27:0] exp_q[$];
  logic [2:0] mctrl;
  logic       mcoll, mseen, p_ovl, p_seen;

  sprite_layer_mixer dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .bg_opaque(bg_opaque),
    .spr_r(spr_r), .spr_g(spr_g), .spr_b(spr_b), .spr_a(spr_a),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_hblank(out_hblank), .out_vblank(out_vblank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic px(input logic sa, input logic [23:0] srgb, input logic bo, input logic [23:0] brgb,
                    input logic hb, input logic vb, input logic hs, input logic vs,
                    input logic rd, input logic wr, input logic [7:0] din);
    {spr_a, bg_opaque, hblank, vblank, hsync, vsync, cpu_rd, cpu_wr} = {sa, bo, hb, vb, hs, vs, rd, wr};
    {spr_r, spr_g, spr_b} = srgb;
    {bg_r, bg_g, bg_b} = brgb;
    cpu_din = din;
  endtask

  task automatic step();
    logic ss, sb, bl, vb;
    logic [23:0] e;
    logic [27:0] x;
    ss = spr_a & mctrl[0];
    sb = bg_opaque & mctrl[2];
    bl = hblank | vblank;
    vb = vblank;
    e = bl ? BORDER : (ss && !(mctrl[1] && sb)) ? {spr_r, spr_g, spr_b} :
        mctrl[2] ? {bg_r, bg_g, bg_b} : 24'h0;
    exp_q.push_back({hsync, vsync, hblank, vblank, e});
    mcoll = (mcoll & ~cpu_rd) | p_ovl;
    mseen = (mseen & ~cpu_rd) | p_seen;
    p_ovl = ss & sb & ~bl;
    p_seen = ss & ~bl;
    if (cpu_wr) mctrl = cpu_din[2:0];
    @(posedge clk);
    #1;
    cpu_wr = 0;
    cpu_rd = 0;
    x = exp_q.pop_front();
    chk("rgb", {8'h0, out_r, out_g, out_b}, {8'h0, x[23:0]});
    chk("sync", {28'h0, out_hsync, out_vsync, out_hblank, out_vblank}, {28'h0, x[27:24]});
    chk("dout", {24'h0, cpu_dout}, {29'h0, vb, mseen, mcoll});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 0, 0, 8'h0);
      step();
    end
  endtask

  initial begin
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 0, 0, 8'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      px(1'($urandom), 24'($urandom), 1'($urandom), 24'($urandom), 1'($urandom), 1'($urandom),
         1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      @(posedge clk);
      #1;
      chk("rst_rgb", {8'h0, out_r, out_g, out_b}, 32'h0);
      chk("rst_sync", {28'h0, out_hsync, out_vsync, out_hblank, out_vblank}, 32'h0);
      chk("rst_dout", {24'h0, cpu_dout}, 32'h0);
    end
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 0, 0, 8'h0);
    reset = 1;
    mctrl = 3'b101;
    {mcoll, mseen, p_ovl, p_seen} = '0;
    exp_q.push_back(28'h0);
    px(1, 24'hFF0000, 1, 24'h00FF00, 0, 0, 1, 0, 0, 0, 8'h0);
    step();
    idle(3);
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 1, 0, 8'h0);
    step();
    idle(2);
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 0, 1, 8'h07);
    step();
    px(1, 24'hFF0000, 1, 24'h00FF00, 0, 0, 0, 0, 0, 0, 8'h0);
    step();
    px(1, 24'hFF0000, 0, 24'h00FF00, 0, 0, 0, 0, 0, 0, 8'h0);
    step();
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 1, 0, 8'h0);
    step();
    idle(2);
    px(1, 24'h123456, 1, 24'h654321, 0, 0, 0, 0, 0, 0, 8'h0);
    step();
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 1, 0, 8'h0);
    step();
    idle(2);
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 1, 0, 8'h0);
    step();
    px(1, 24'hABCDEF, 1, 24'h111111, 1, 0, 0, 0, 0, 0, 8'h0);
    step();
    px(1, 24'hABCDEF, 1, 24'h111111, 0, 1, 0, 1, 0, 0, 8'h0);
    step();
    idle(2);
    px(0, 24'h0, 0, 24'h0, 0, 0, 0, 0, 0, 1, 8'h00);
    step();
    px(1, 24'hFF00FF, 1, 24'h00FF00, 0, 0, 0, 0, 0, 0, 8'h0);
    step();
    idle(2);
    for (int i = 0; i < 300; i++) begin
      px(1'($urandom), 24'($urandom), 1'($urandom), 24'($urandom), $urandom_range(0, 7) == 0,
         $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0,
         $urandom_range(0, 15) == 0, 8'($urandom));
      step();
    end
    px(1, 24'hFFFFFF, 1, 24'hFFFFFF, 0, 1, 1, 1, 0, 0, 8'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 0;
    #1;
    chk("mid_rst_rgb", {8'h0, out_r, out_g, out_b}, 32'h0);
    chk("mid_rst_sync", {28'h0, out_hsync, out_vsync, out_hblank, out_vblank}, 32'h0);
    chk("mid_rst_dout", {24'h0, cpu_dout}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
